// File: rtl/sequence_pkg.sv
// Shared types and constants for the sequence playback block.
// Optional zero-terminated playback is enabled by defining SEQ_ZERO_TERMINATE_EN.
package sequence_pkg;

  localparam int SEQ_W       = 20;
  localparam int SYM_W       = 4;
  localparam int NUM_SYMBOLS = 5;
  localparam int ADDR_W      = 5;
  localparam int CNT_W       = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SHOW = 3'd3,
    GAP  = 3'd4,
    DONE = 3'd5
  } state_t;

  // Symbol idx of a stored word; index 0 is the most significant nibble.
  function automatic logic [SYM_W-1:0] sym_at(input logic [SEQ_W-1:0] word,
                                                input logic [IDX_W-1:0] idx);
    logic [SEQ_W-1:0] sh;
    sh = word >> (SYM_W * (NUM_SYMBOLS - 1 - int'(idx)));
    return sh[SYM_W-1:0];
  endfunction

endpackage

// File: rtl/playback_timer.sv
// Loadable 8-bit down-counter; expired is high while the count sits at zero.
// The count saturates at zero instead of wrapping.
module playback_timer
  import sequence_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/sequence_playback.sv
// Fetches one 20-bit word from RAM and shows its five nibbles MSB first with
// hold/gap timing. Define SEQ_ZERO_TERMINATE_EN to stop playback at the first zero nibble.
module sequence_playback
  import sequence_pkg::*;
#(
  parameter int                HOLD_CYCLES = 8,
  parameter int                GAP_CYCLES  = 2,
  parameter logic [ADDR_W-1:0] SEQ_ADDR    = 5'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              RAM_R,
  output logic [ADDR_W-1:0] RAM_addr,
  input  logic [SEQ_W-1:0]  RAM_data,
  output logic [SYM_W-1:0]  symbol,
  output logic              symbol_valid,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state_o
);

`ifdef SEQ_ZERO_TERMINATE_EN
  localparam bit ZERO_TERM = 1'b1;
`else
  localparam bit ZERO_TERM = 1'b0;
`endif

  // Counter runs value..0, so a load of N-1 yields N cycles in the state.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SYMBOLS - 1);

  state_t            state_q, state_d;
  logic [SEQ_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_next;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_value;
  logic              tmr_expired;

  logic              ram_r_q, ram_r_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [SYM_W-1:0]  symbol_q, symbol_d;
  logic              symbol_valid_q, symbol_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  playback_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  assign idx_next = idx_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    tmr_load  = 1'b0;
    tmr_value = HOLD_LOAD;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) state_d = READ;
      end
      READ: state_d = WAIT;
      WAIT: begin
        word_d = RAM_data;
        idx_d  = '0;
        if (ZERO_TERM && (sym_at(RAM_data, '0) == '0)) begin
          state_d = DONE;
        end else begin
          state_d  = SHOW;
          tmr_load = 1'b1;
        end
      end
      SHOW: begin
        if (tmr_expired) begin
          // The zero check looks ahead so a terminating nibble gets no gap either.
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else if (ZERO_TERM && (sym_at(word_q, idx_next) == '0)) begin
            state_d = DONE;
          end else if (GAP_CYCLES == 0) begin
            state_d  = SHOW;
            idx_d    = idx_next;
            tmr_load = 1'b1;
          end else begin
            state_d   = GAP;
            tmr_load  = 1'b1;
            tmr_value = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (tmr_expired) begin
          state_d  = SHOW;
          idx_d    = idx_next;
          tmr_load = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    busy_d         = (state_d != IDLE);
    ram_r_d        = (state_d == READ);
    ram_addr_d     = (state_d == READ) ? SEQ_ADDR : '0;
    done_d         = (state_d == DONE);
    symbol_valid_d = (state_d == SHOW);
    symbol_d       = (state_d == SHOW) ? sym_at(word_d, idx_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      word_q         <= '0;
      idx_q          <= '0;
      ram_r_q        <= 1'b0;
      ram_addr_q     <= '0;
      symbol_q       <= '0;
      symbol_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_q         <= word_d;
      idx_q          <= idx_d;
      ram_r_q        <= ram_r_d;
      ram_addr_q     <= ram_addr_d;
      symbol_q       <= symbol_d;
      symbol_valid_q <= symbol_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign RAM_R        = ram_r_q;
  assign RAM_addr     = ram_addr_q;
  assign symbol       = symbol_q;
  assign symbol_valid = symbol_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sequence_playback.sv
// Self-checking bench for sequence_playback: two instances (4/2 timing and 1/0 timing)
// checked cycle by cycle against a trace model built from the playback rules.
module tb_sequence_playback;
  import sequence_pkg::*;

  localparam int          A_HOLD = 4;
  localparam int          A_GAP  = 2;
  localparam logic [4:0]  A_ADDR = 5'd0;
  localparam int          B_HOLD = 1;
  localparam int          B_GAP  = 0;
  localparam logic [4:0]  B_ADDR = 5'd21;

  // clock / reset / shared stimulus
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sel;
  logic [19:0] ram_data;

  always #5 clk = ~clk;

  logic        a_start, a_ram_r, a_valid, a_busy, a_done;
  logic [4:0]  a_addr;
  logic [3:0]  a_sym;
  state_t      a_state;
  logic        b_start, b_ram_r, b_valid, b_busy, b_done;
  logic [4:0]  b_addr;
  logic [3:0]  b_sym;
  state_t      b_state;

  assign a_start = start & ~sel;
  assign b_start = start & sel;

  sequence_playback #(.HOLD_CYCLES(A_HOLD), .GAP_CYCLES(A_GAP), .SEQ_ADDR(A_ADDR)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .RAM_R(a_ram_r), .RAM_addr(a_addr),
    .RAM_data(ram_data), .symbol(a_sym), .symbol_valid(a_valid), .busy(a_busy),
    .done(a_done), .dbg_state_o(a_state)
  );

  sequence_playback #(.HOLD_CYCLES(B_HOLD), .GAP_CYCLES(B_GAP), .SEQ_ADDR(B_ADDR)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .RAM_R(b_ram_r), .RAM_addr(b_addr),
    .RAM_data(ram_data), .symbol(b_sym), .symbol_valid(b_valid), .busy(b_busy),
    .done(b_done), .dbg_state_o(b_state)
  );

  // observation of the selected instance, packed {RAM_R, busy, valid, symbol, done}
  logic [7:0] obs_a, obs_b, obs;
  logic [4:0] obs_addr;
  assign obs_a    = {a_ram_r, a_busy, a_valid, a_sym, a_done};
  assign obs_b    = {b_ram_r, b_busy, b_valid, b_sym, b_done};
  assign obs      = sel ? obs_b : obs_a;
  assign obs_addr = sel ? b_addr : a_addr;

  // scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic [19:0] ram_q[$];
  bit          start_q[$];

  function automatic logic [7:0] pack(bit rr, bit bz, bit v, logic [3:0] s, bit d);
    return {rr, bz, v, s, d};
  endfunction

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'h00);
      ram_q.push_back(20'($urandom));
      start_q.push_back(1'b0);
    end
  endtask

  // Expected trace of one playback, first entry = cycle after the accepting edge.
  task automatic add_play(input logic [19:0] w, input logic [19:0] late);
    int         h;
    int         g;
    logic [3:0] syms[$];
    logic [19:0] nib;
    h = sel ? B_HOLD : A_HOLD;
    g = sel ? B_GAP : A_GAP;
    for (int k = 0; k < 5; k++) begin
      nib = (w >> (4 * (4 - k))) & 20'hF;
`ifdef SEQ_ZERO_TERMINATE_EN
      if (nib == 20'h0) break;
`endif
      syms.push_back(nib[3:0]);
    end
    exp_q.push_back(pack(1, 1, 0, 4'h0, 0)); ram_q.push_back(20'($urandom)); start_q.push_back(0);
    exp_q.push_back(pack(0, 1, 0, 4'h0, 0)); ram_q.push_back(w);             start_q.push_back(0);
    for (int k = 0; k < syms.size(); k++) begin
      for (int c = 0; c < h; c++) begin
        exp_q.push_back(pack(0, 1, 1, syms[k], 0)); ram_q.push_back(late); start_q.push_back(0);
      end
      if (k != syms.size() - 1) begin
        for (int c = 0; c < g; c++) begin
          exp_q.push_back(pack(0, 1, 0, 4'h0, 0)); ram_q.push_back(late); start_q.push_back(0);
        end
      end
    end
    exp_q.push_back(pack(0, 1, 0, 4'h0, 1)); ram_q.push_back(late); start_q.push_back(0);
  endtask

  // driver: pulse start, then walk the expected trace; stops after 'limit' entries
  task automatic run_trace(input string name, input int limit);
    logic [4:0] exp_addr;
    int         n;
    exp_addr = sel ? B_ADDR : A_ADDR;
    n = (limit < exp_q.size()) ? limit : exp_q.size();
    @(negedge clk);
    start    = 1'b1;
    ram_data = 20'($urandom);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: {RAM_R,busy,valid,sym,done} got %h expected %h",
                 name, i, obs, exp_q[i]);
      end
      if (exp_q[i][7]) begin
        n_tests++;
        if (obs_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL %s addr cycle %0d: got %0d expected %0d", name, i, obs_addr, exp_addr);
        end
      end
      start    = start_q[i];
      ram_data = ram_q[i];
    end
    start = 1'b0;
    exp_q.delete();
    ram_q.delete();
    start_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if (obs_a !== 8'h00 || obs_b !== 8'h00 || a_addr !== 5'd0 || b_addr !== 5'd0 ||
        a_state !== IDLE || b_state !== IDLE) begin
      n_fail++;
      $display("FAIL %s: a=%h b=%h addr_a=%0d addr_b=%0d state_a=%0d state_b=%0d expected all zero/IDLE",
               name, obs_a, obs_b, a_addr, b_addr, a_state, b_state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    add_play(20'h3A5C1, 20'h3A5C1);
    add_idle(2);
    run_trace("basic_3A5C1", 1000);
  endtask

  task automatic test_start_while_busy();
    int r;
    sel = 1'b0;
    add_play(20'h3A5C1, 20'h3A5C1);
    start_q[2 + A_HOLD + A_GAP + 1] = 1'b1;
    r = $urandom_range(0, exp_q.size() - 2);
    start_q[r] = 1'b1;
    add_idle(2);
    run_trace("start_while_busy", 1000);
  endtask

  task automatic test_data_change();
    sel = 1'b0;
    add_play(20'h3A5C1, 20'hFFFFF);
    add_idle(1);
    run_trace("data_change", 1000);
  endtask

  task automatic test_async_reset();
    sel = 1'b0;
    add_play(20'h3A5C1, 20'h3A5C1);
    run_trace("pre_reset", 2 + A_HOLD + 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset_in_gap");
    @(negedge clk);
    rst = 1'b0;
    add_play(20'h3A5C1, 20'h3A5C1);
    add_idle(1);
    run_trace("replay_after_reset", 1000);
  endtask

  task automatic test_start_in_done();
    int d;
    sel = 1'b0;
    add_play(20'($urandom), 20'($urandom));
    d = exp_q.size() - 1;
    start_q[d] = 1'b1;
    add_idle(3);
    run_trace("start_in_done", 1000);
  endtask

  task automatic test_back_to_back();
    int d;
    sel = 1'b0;
    add_play(20'h13579, 20'($urandom));
    d = exp_q.size() - 1;
    start_q[d] = 1'b1;
    add_idle(1);
    start_q[d + 1] = 1'b1;
    add_play(20'hECA86, 20'($urandom));
    add_idle(1);
    run_trace("back_to_back", 1000);
  endtask

  task automatic test_fast();
    sel = 1'b1;
    add_play(20'h12345, 20'($urandom));
    add_idle(2);
    run_trace("fast_12345", 1000);
  endtask

  task automatic test_zero_nibbles();
    sel = 1'b0;
    add_play(20'h7B000, 20'h7B000);
    add_idle(1);
    run_trace("zero_7B000", 1000);
    add_play(20'h00000, 20'h00000);
    add_idle(1);
    run_trace("zero_00000", 1000);
    sel = 1'b1;
    add_play(20'h7B000, 20'($urandom));
    add_idle(1);
    run_trace("fast_zero_7B000", 1000);
  endtask

  task automatic test_random();
    logic [19:0] w;
    for (int it = 0; it < 20; it++) begin
      sel = 1'($urandom_range(0, 1));
      w = 20'($urandom);
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 3) == 0) w[4*k +: 4] = 4'h0;
      end
      add_play(w, 20'($urandom));
      start_q[$urandom_range(0, exp_q.size() - 2)] = 1'b1;
      add_idle($urandom_range(1, 3));
      run_trace($sformatf("random_%0d_%05h", it, w), 1000);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    sel      = 1'b0;
    ram_data = '0;
    test_reset();
    test_basic();
    test_start_while_busy();
    test_data_change();
    test_async_reset();
    test_start_in_done();
    test_back_to_back();
    test_fast();
    test_zero_nibbles();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
